alu_exec_stage: RTL and testbench

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_shifter_serial.sv | 57 +++++
 rtl/alu_exec_stage.sv | 203 ++++++++++++++++++++
 tb/tb_alu_exec_stage.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU execute stage: ALU operation codes as issued
// by the ALU controller, and the execute-stage FSM state encoding.
// Optional feature macro used by the stage: ALU_SERIAL_SHIFT_EN.
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_ADD = 4'b0011;
   localparam logic [3:0] ALU_EQ  = 4'b0101;
   localparam logic [3:0] ALU_NE  = 4'b0110;
   localparam logic [3:0] ALU_LT  = 4'b0111;
   localparam logic [3:0] ALU_GE  = 4'b1000;
   localparam logic [3:0] ALU_SRL = 4'b1001;
   localparam logic [3:0] ALU_SLL = 4'b1010;
   localparam logic [3:0] ALU_LUI = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } alu_state_e;

   function automatic logic is_shift_op(input logic [3:0] op);
      return (op == ALU_SRL) || (op == ALU_SLL);
   endfunction

endpackage

// File: rtl/alu_shifter_serial.sv
// -----------------------------------------------------------------------------
// alu_shifter_serial
// Bit-serial shifter: shifts one bit position per clock.
//   clk, reset : clock, asynchronous active-high reset
//   start      : load operand/shamt/direction (shamt must be non-zero)
//   kill       : abandon the shift in progress
//   dir        : 1 = shift left, 0 = logical shift right
//   shamt      : number of bit positions
//   operand    : value to shift
//   done       : final bit is being shifted this cycle, or shift already done
//   result     : final shifted value whenever done is high
// Only instantiated when ALU_SERIAL_SHIFT_EN is defined.
// -----------------------------------------------------------------------------
module alu_shifter_serial #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  kill,
   input  logic                  dir,
   input  logic [4:0]            shamt,
   input  logic [DATA_WIDTH-1:0] operand,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   logic [DATA_WIDTH-1:0] data;
   logic [DATA_WIDTH-1:0] data_next;
   logic [4:0]            cnt;
   logic                  dir_q;

   assign data_next = dir_q ? (data << 1) : (data >> 1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data  <= '0;
         cnt   <= '0;
         dir_q <= 1'b0;
      end else if (kill) begin
         cnt <= '0;
      end else if (start) begin
         data  <= operand;
         cnt   <= shamt;
         dir_q <= dir;
      end else if (cnt != 5'd0) begin
         data <= data_next;
         cnt  <= cnt - 5'd1;
      end
   end

   // The last bit is shifted combinationally so the stage can capture the
   // result on the same edge that would have performed the final shift.
   assign done   = (cnt <= 5'd1);
   assign result = (cnt == 5'd0) ? data : data_next;

endmodule

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
// Pipeline execute stage: computes the ALU result for one operation and
// presents it, with its destination register and branch decision, on a
// registered valid/ready output.
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid / in_ready  : issue handshake from upstream
//   op_i, src_a_i/src_b_i: ALU op code and operands (src_b_i[4:0] = shamt)
//   rd_i, reg_write_i, is_branch_i : sideband carried to the output
//   flush_i              : kill in-flight and incoming operation
//   out_valid / out_ready: handshake towards EX/MEM
//   result_o, rd_o, reg_write_o, branch_taken_o : registered outputs
//   busy_o               : serial shift in progress
//   fsm_state            : current FSM state (alu_state_e encoding)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; while valid=1 and ready=0 the sender holds its payload stable.
// Macro ALU_SERIAL_SHIFT_EN: shifts with non-zero shamt run on the bit-serial
// shifter (one bit per cycle); otherwise all shifts are single-cycle.
// -----------------------------------------------------------------------------
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            op_i,
   input  logic [DATA_WIDTH-1:0] src_a_i,
   input  logic [DATA_WIDTH-1:0] src_b_i,
   input  logic [4:0]            rd_i,
   input  logic                  reg_write_i,
   input  logic                  is_branch_i,
   input  logic                  flush_i,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic [4:0]            rd_o,
   output logic                  reg_write_o,
   output logic                  branch_taken_o,
   output logic                  busy_o,
   output logic [1:0]            fsm_state
);

   localparam logic [DATA_WIDTH-2:0] UPPER_ZERO = '0;

   alu_state_e            state;
   alu_state_e            state_next;
   logic [4:0]            shamt;
   logic                  out_free;
   logic                  accept;
   logic                  serial_shift;
   logic                  single_load;
   logic                  shift_start;
   logic                  shift_wr;
   logic                  shift_done;
   logic [DATA_WIDTH-1:0] shift_result;
   logic [DATA_WIDTH-1:0] alu_result;
   logic [4:0]            pend_rd;
   logic                  pend_reg_write;
   logic                  pend_is_branch;

   assign shamt     = src_b_i[4:0];
   assign out_free  = !out_valid || out_ready;
   assign in_ready  = (state == ST_IDLE) && !flush_i && out_free;
   assign accept    = in_valid && in_ready;
   assign fsm_state = state;

   // ---------------- combinational ALU ----------------
   always_comb begin
      alu_result = '0;
      case (op_i)
         ALU_AND: alu_result = src_a_i & src_b_i;
         ALU_OR:  alu_result = src_a_i | src_b_i;
         ALU_XOR: alu_result = src_a_i ^ src_b_i;
         ALU_ADD: alu_result = src_a_i + src_b_i;
         ALU_EQ:  alu_result = {UPPER_ZERO, src_a_i == src_b_i};
         ALU_NE:  alu_result = {UPPER_ZERO, src_a_i != src_b_i};
         ALU_LT:  alu_result = {UPPER_ZERO, $signed(src_a_i) <  $signed(src_b_i)};
         ALU_GE:  alu_result = {UPPER_ZERO, $signed(src_a_i) >= $signed(src_b_i)};
         ALU_SRL: alu_result = src_a_i >> shamt;
         ALU_SLL: alu_result = src_a_i << shamt;
         ALU_LUI: alu_result = src_b_i;
         default: alu_result = '0;
      endcase
   end

`ifdef ALU_SERIAL_SHIFT_EN
   // Zero-distance shifts gain nothing from the serial path; keep them at
   // single-cycle latency through the barrel shifter above.
   assign serial_shift = is_shift_op(op_i) && (shamt != 5'd0);

   alu_shifter_serial #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_shifter (
      .clk     (clk),
      .reset   (reset),
      .start   (shift_start),
      .kill    (flush_i),
      .dir     (op_i == ALU_SLL),
      .shamt   (shamt),
      .operand (src_a_i),
      .done    (shift_done),
      .result  (shift_result)
   );

   // Sideband of the shift in flight, written out with its result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_rd        <= '0;
         pend_reg_write <= 1'b0;
         pend_is_branch <= 1'b0;
      end else if (shift_start) begin
         pend_rd        <= rd_i;
         pend_reg_write <= reg_write_i;
         pend_is_branch <= is_branch_i;
      end
   end
`else
   assign serial_shift   = 1'b0;
   assign shift_done     = 1'b0;
   assign shift_result   = '0;
   assign pend_rd        = '0;
   assign pend_reg_write = 1'b0;
   assign pend_is_branch = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state;
`ifdef ALU_SERIAL_SHIFT_EN
      if (flush_i) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (accept && serial_shift) state_next = ST_SHIFT;
            ST_SHIFT: if (shift_done) state_next = out_free ? ST_IDLE : ST_HOLD;
            ST_HOLD:  if (out_free) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
         endcase
      end
`else
      state_next = ST_IDLE;
`endif
   end

   // ---------------- FSM: outputs ----------------
   // HOLD is defensive: the output register is always free when a shift is
   // accepted, but the shift result must never overwrite an unconsumed one.
   always_comb begin
      busy_o      = 1'b0;
      shift_start = 1'b0;
      shift_wr    = 1'b0;
      case (state)
         ST_IDLE:  shift_start = accept && serial_shift;
         ST_SHIFT: begin
`ifdef ALU_SERIAL_SHIFT_EN
            busy_o   = 1'b1;
`endif
            shift_wr = !flush_i && shift_done && out_free;
         end
         ST_HOLD:  shift_wr = !flush_i && out_free;
         default:  ;
      endcase
   end

   assign single_load = accept && !serial_shift;

   // ---------------- output register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid      <= 1'b0;
         result_o       <= '0;
         rd_o           <= '0;
         reg_write_o    <= 1'b0;
         branch_taken_o <= 1'b0;
      end else if (flush_i) begin
         out_valid <= 1'b0;
      end else if (single_load) begin
         out_valid      <= 1'b1;
         result_o       <= alu_result;
         rd_o           <= rd_i;
         reg_write_o    <= reg_write_i;
         branch_taken_o <= is_branch_i && alu_result[0];
      end else if (shift_wr) begin
         out_valid      <= 1'b1;
         result_o       <= shift_result;
         rd_o           <= pend_rd;
         reg_write_o    <= pend_reg_write;
         branch_taken_o <= pend_is_branch && shift_result[0];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
// Directed bench for alu_exec_stage: a table of single operations with
// hand-computed results, followed by hand-written sequences for backpressure,
// back-to-back issue, flush, asynchronous reset and (with
// ALU_SERIAL_SHIFT_EN) serial-shift timing.
// -----------------------------------------------------------------------------
module tb_alu_exec_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op_i;
   logic [31:0] src_a_i;
   logic [31:0] src_b_i;
   logic [4:0]  rd_i;
   logic        reg_write_i;
   logic        is_branch_i;
   logic        flush_i;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result_o;
   logic [4:0]  rd_o;
   logic        reg_write_o;
   logic        branch_taken_o;
   logic        busy_o;
   logic [1:0]  fsm_state;

   int checks = 0;
   int errors = 0;

   alu_exec_stage #(.DATA_WIDTH(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .op_i           (op_i),
      .src_a_i        (src_a_i),
      .src_b_i        (src_b_i),
      .rd_i           (rd_i),
      .reg_write_i    (reg_write_i),
      .is_branch_i    (is_branch_i),
      .flush_i        (flush_i),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .result_o       (result_o),
      .rd_o           (rd_o),
      .reg_write_o    (reg_write_o),
      .branch_taken_o (branch_taken_o),
      .busy_o         (busy_o),
      .fsm_state      (fsm_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- check helper ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        br;
      logic [31:0] exp_res;
      logic        exp_br;
   } vec_t;

   localparam int NVEC = 20;
   vec_t vecs[NVEC];

   function automatic int exp_latency(input logic [3:0] op, input logic [31:0] b);
      int lat;
      lat = 1;
`ifdef ALU_SERIAL_SHIFT_EN
      if ((op == 4'b1001 || op == 4'b1010) && b[4:0] != 5'd0) lat = int'(b[4:0]) + 1;
`endif
      return lat;
   endfunction

   // Driver: issue vecs[idx] and wait (bounded) for its result.
   task automatic run_vec(input int idx);
      int lat;
      logic [31:0] idx_bits;
      idx_bits    = idx;
      op_i        = vecs[idx].op;
      src_a_i     = vecs[idx].a;
      src_b_i     = vecs[idx].b;
      is_branch_i = vecs[idx].br;
      rd_i        = idx_bits[4:0] + 5'd1;
      reg_write_i = idx_bits[0];
      in_valid    = 1'b1;
      #1;
      check($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("v%0d latency", idx), lat, exp_latency(vecs[idx].op, vecs[idx].b));
      check($sformatf("v%0d result", idx), result_o, vecs[idx].exp_res);
      check($sformatf("v%0d branch_taken", idx), {31'd0, branch_taken_o}, {31'd0, vecs[idx].exp_br});
      check($sformatf("v%0d rd", idx), {27'd0, rd_o}, {27'd0, idx_bits[4:0] + 5'd1});
      check($sformatf("v%0d reg_write", idx), {31'd0, reg_write_o}, {31'd0, idx_bits[0]});
      @(posedge clk); #1;
      check($sformatf("v%0d consumed", idx), {31'd0, out_valid}, 32'd0);
   endtask

   task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
      op_i        = op;
      src_a_i     = a;
      src_b_i     = b;
      rd_i        = rd;
      reg_write_i = 1'b1;
      is_branch_i = 1'b0;
      in_valid    = 1'b1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int seen;
      int busy_cnt;
      int guard;

      //            op       A             B             br    result        br_taken
      vecs[0]  = '{4'b0000, 32'hF0F01234, 32'h0FF0FFFF, 1'b0, 32'h00F01234, 1'b0};
      vecs[1]  = '{4'b0001, 32'h000000F0, 32'h0000000F, 1'b0, 32'h000000FF, 1'b0};
      vecs[2]  = '{4'b0010, 32'hAAAA5555, 32'hFFFF0000, 1'b0, 32'h55555555, 1'b0};
      vecs[3]  = '{4'b0011, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b0};
      vecs[4]  = '{4'b0011, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
      vecs[5]  = '{4'b0101, 32'h00000005, 32'h00000005, 1'b1, 32'h00000001, 1'b1};
      vecs[6]  = '{4'b0110, 32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b0};
      vecs[7]  = '{4'b0111, 32'hFFFFFFFE, 32'h00000001, 1'b1, 32'h00000001, 1'b1};
      vecs[8]  = '{4'b1000, 32'hFFFFFFFE, 32'h00000001, 1'b1, 32'h00000000, 1'b0};
      vecs[9]  = '{4'b0111, 32'h00000001, 32'hFFFFFFFE, 1'b1, 32'h00000000, 1'b0};
      vecs[10] = '{4'b1000, 32'h00000007, 32'h00000007, 1'b1, 32'h00000001, 1'b1};
      vecs[11] = '{4'b1001, 32'h80000000, 32'h00000004, 1'b0, 32'h08000000, 1'b0};
      vecs[12] = '{4'b1010, 32'h00000001, 32'h00000005, 1'b0, 32'h00000020, 1'b0};
      vecs[13] = '{4'b1010, 32'h000000FF, 32'h00000000, 1'b0, 32'h000000FF, 1'b0};
      vecs[14] = '{4'b1001, 32'hF0000000, 32'hFFFFFFE4, 1'b0, 32'h0F000000, 1'b0};
      vecs[15] = '{4'b1100, 32'h12345678, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
      vecs[16] = '{4'b0100, 32'h0000000F, 32'h0000000F, 1'b0, 32'h00000000, 1'b0};
      vecs[17] = '{4'b1111, 32'hFFFFFFFF, 32'h00000003, 1'b1, 32'h00000000, 1'b0};
      vecs[18] = '{4'b0110, 32'h00000003, 32'h00000004, 1'b1, 32'h00000001, 1'b1};
      vecs[19] = '{4'b0101, 32'h00000001, 32'h00000001, 1'b0, 32'h00000001, 1'b0};

      // ---- clock/reset ----
      reset       = 1'b1;
      in_valid    = 1'b0;
      op_i        = '0;
      src_a_i     = '0;
      src_b_i     = '0;
      rd_i        = '0;
      reg_write_i = 1'b0;
      is_branch_i = 1'b0;
      flush_i     = 1'b0;
      out_ready   = 1'b1;
      #12;
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset result", result_o, 32'd0);
      check("reset rd", {27'd0, rd_o}, 32'd0);
      check("reset reg_write", {31'd0, reg_write_o}, 32'd0);
      check("reset branch_taken", {31'd0, branch_taken_o}, 32'd0);
      check("reset busy", {31'd0, busy_o}, 32'd0);
      check("reset fsm_state", {30'd0, fsm_state}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // ---- table ----
      for (int i = 0; i < NVEC; i++) run_vec(i);

      // ---- backpressure: OR held for 3 cycles, new op taken on release ----
      out_ready = 1'b0;
      drive_op(4'b0001, 32'h000000F0, 32'h0000000F, 5'd3);
      @(posedge clk); #1;
      drive_op(4'b0011, 32'h00000001, 32'h00000001, 5'd4);
      for (int c = 0; c < 3; c++) begin
         check($sformatf("bp%0d out_valid", c), {31'd0, out_valid}, 32'd1);
         check($sformatf("bp%0d result", c), result_o, 32'h000000FF);
         check($sformatf("bp%0d rd", c), {27'd0, rd_o}, 32'd3);
         check($sformatf("bp%0d in_ready", c), {31'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      check("bp release in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp next out_valid", {31'd0, out_valid}, 32'd1);
      check("bp next result", result_o, 32'd2);
      check("bp next rd", {27'd0, rd_o}, 32'd4);
      @(posedge clk); #1;
      check("bp drained", {31'd0, out_valid}, 32'd0);

      // ---- back-to-back throughput ----
      for (int i = 0; i < 4; i++) begin
         drive_op(4'b0011, i, 32'd100, 5'(i));
         @(posedge clk); #1;
         check($sformatf("b2b%0d out_valid", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("b2b%0d result", i), result_o, 32'd100 + i);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("b2b drained", {31'd0, out_valid}, 32'd0);

      // ---- flush kills held result and incoming op ----
      out_ready = 1'b0;
      drive_op(4'b0010, 32'd3, 32'd5, 5'd7);
      @(posedge clk); #1;
      check("flush pre result", result_o, 32'd6);
      drive_op(4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8);
      flush_i = 1'b1;
      #1;
      check("flush in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      flush_i  = 1'b0;
      in_valid = 1'b0;
      check("flush out_valid", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("flush dropped op", {31'd0, out_valid}, 32'd0);

      // ---- asynchronous reset between edges ----
      out_ready = 1'b0;
      drive_op(4'b0011, 32'd5, 32'd6, 5'd9);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("areset pre result", result_o, 32'd11);
      #3;
      reset = 1'b1;
      #1;
      check("areset out_valid", {31'd0, out_valid}, 32'd0);
      check("areset result", result_o, 32'd0);
      #1;
      reset     = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;

`ifdef ALU_SERIAL_SHIFT_EN
      // ---- serial shift: 1 << 5 takes 5 busy cycles ----
      drive_op(4'b1010, 32'd1, 32'd5, 5'd10);
      @(posedge clk); #1;
      in_valid = 1'b0;
      busy_cnt = 0;
      guard    = 0;
      while (busy_o && guard < 40) begin
         busy_cnt++;
         guard++;
         @(posedge clk); #1;
      end
      check("sshift busy cycles", busy_cnt, 32'd5);
      check("sshift out_valid", {31'd0, out_valid}, 32'd1);
      check("sshift result", result_o, 32'h20);
      check("sshift rd", {27'd0, rd_o}, 32'd10);
      check("sshift fsm idle", {30'd0, fsm_state}, 32'd0);
      @(posedge clk); #1;

      // ---- flush on 2nd cycle of an 8-bit shift ----
      drive_op(4'b1010, 32'd1, 32'd8, 5'd11);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("sflush busy c1", {31'd0, busy_o}, 32'd1);
      check("sflush fsm shift", {30'd0, fsm_state}, 32'd1);
      @(posedge clk); #1;
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      check("sflush busy", {31'd0, busy_o}, 32'd0);
      check("sflush out_valid", {31'd0, out_valid}, 32'd0);
      check("sflush fsm idle", {30'd0, fsm_state}, 32'd0);
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         if (out_valid) seen++;
         @(posedge clk); #1;
      end
      check("sflush no result", seen, 32'd0);
`else
      // ---- shifts stay single-cycle, busy never rises ----
      drive_op(4'b1010, 32'd1, 32'd5, 5'd10);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bshift busy", {31'd0, busy_o}, 32'd0);
      check("bshift fsm idle", {30'd0, fsm_state}, 32'd0);
      check("bshift out_valid", {31'd0, out_valid}, 32'd1);
      check("bshift result", result_o, 32'h20);
      @(posedge clk); #1;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
